dmem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the byte-wide data memory.
- Accepts 32-bit word load/store requests from requester 0 (CPU load/store unit) and requester 1 (debug/DMA port).
- Grants one requester at a time, round-robin.
- Splits each word access into four byte beats on the memory port, little-endian, and returns a single-cycle ack.

---
 rtl/dmem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter for two word-wide requesters in front of a byte-wide data memory.
// Each aligned word access is sequenced as four little-endian byte beats, then acked for one cycle.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_ack,
  output logic [31:0]       r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_ack,
  output logic [31:0]       r1_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_data_in,
  input  logic [7:0]        mem_data_out,
  output logic              mem_read,
  output logic              mem_write,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_t              state_q, state_d;
  logic [1:0]          beat_q;
  logic                last_grant_q, grant_id_q, we_q, err_q;
  logic [ADDR_W-3:0]   word_q;
  logic [31:0]         wdata_q;
  logic [23:0]         rbuf_q;
  logic [31:0]         r0_rdata_q, r1_rdata_q;

  // Arbitration: a lone request wins; on a tie the requester not granted last time wins.
  logic              any_req, pick, sel_we, sel_mis;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  always_comb begin
    any_req   = r0_req | r1_req;
    pick      = (r0_req && r1_req) ? ~last_grant_q : r1_req;
    sel_we    = pick ? r1_we    : r0_we;
    sel_addr  = pick ? r1_addr  : r0_addr;
    sel_wdata = pick ? r1_wdata : r0_wdata;
    sel_mis   = (sel_addr[1:0] != 2'b00);
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_req) state_d = sel_mis ? RESP : BEAT;
      BEAT: if (beat_q == LAST_BEAT) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_data_in = 8'h00;
    if (state_q == BEAT) begin
      mem_read    = ~we_q;
      mem_write   = we_q;
      mem_address = {word_q, beat_q};
      if (we_q) begin
        case (beat_q)
          2'd0:    mem_data_in = wdata_q[7:0];
          2'd1:    mem_data_in = wdata_q[15:8];
          2'd2:    mem_data_in = wdata_q[23:16];
          default: mem_data_in = wdata_q[31:24];
        endcase
      end
    end
  end

  assign busy     = (state_q == BEAT) || (state_q == RESP);
  assign r0_ack   = (state_q == RESP) && !grant_id_q;
  assign r1_ack   = (state_q == RESP) &&  grant_id_q;
  assign err      = (state_q == RESP) && err_q;
  assign grant_id = grant_id_q;
  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      beat_q       <= 2'd0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      word_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_id_q   <= pick;
            last_grant_q <= pick;
            we_q         <= sel_we;
            word_q       <= sel_addr[ADDR_W-1:2];
            wdata_q      <= sel_wdata;
            err_q        <= sel_mis;
            beat_q       <= 2'd0;
            if (sel_mis) begin
              if (pick) r1_rdata_q <= '0;
              else      r0_rdata_q <= '0;
            end
          end
        end
        BEAT: begin
          beat_q <= beat_q + 2'd1;
          case (beat_q)
            2'd0: rbuf_q[7:0]   <= mem_data_out;
            2'd1: rbuf_q[15:8]  <= mem_data_out;
            2'd2: rbuf_q[23:16] <= mem_data_out;
            default: begin
              // Final byte comes straight from the memory so the word is complete in RESP.
              if (grant_id_q) r1_rdata_q <= we_q ? 32'h0 : {mem_data_out, rbuf_q};
              else            r0_rdata_q <= we_q ? 32'h0 : {mem_data_out, rbuf_q};
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized word transactions
// checked against a transaction-level byte-array model of memory and a round-robin grant model.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ack, r1_ack, err, mem_read, mem_write, busy, grant_id;
  logic [31:0] r0_rdata, r1_rdata, mem_address;
  logic [7:0]  mem_data_in, mem_data_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_last;

  logic [7:0] dev_mem [256];
  logic [7:0] ref_mem [256];

  dmem_port_arbiter #(.ADDR_W(32), .BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .err(err), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_read(mem_read), .mem_write(mem_write),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: combinational read, write on the mid-cycle falling edge.
  assign mem_data_out = dev_mem[mem_address[7:0]];
  always @(negedge clk) if (mem_write) dev_mem[mem_address[7:0]] <= mem_data_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit id, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (id) begin r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; end
    else    begin r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [7:0] a;
    a = addr[7:0];
    return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_r0_ack", r0_ack, 0);
    check("rst_r1_ack", r1_ack, 0);
    check("rst_err", err, 0);
    check("rst_r0_rdata", r0_rdata, 0);
    check("rst_r1_rdata", r1_rdata, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_data_in", mem_data_in, 0);
    check("rst_mem_rw", {mem_read, mem_write}, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    reset = 1'b1;
    model_last = 1'b1;
  endtask

  // One complete transaction from the IDLE cycle through the ack cycle.
  task automatic txn(input bit id, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit drop, input bit tie);
    bit          mis;
    logic [31:0] exp;
    logic [7:0]  a;
    mis = (addr[1:0] != 2'b00);
    a   = addr[7:0];
    exp = (mis || we) ? 32'h0 : ref_word(addr);
    @(negedge clk);
    drive(id, 1'b1, we, addr, wdata);
    drive(!id, tie, 1'b0, {24'h0, 6'($urandom_range(0, 60)), 2'b00}, $urandom);
    @(posedge clk);
    #1;
    model_last = id;
    check("grant_id", grant_id, id);
    drive(!id, 1'b0, 1'b0, 32'h0, 32'h0);
    if (!mis) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check($sformatf("beat%0d_busy", k), busy, 1);
        check($sformatf("beat%0d_rw", k), {mem_read, mem_write}, {!we, we});
        check($sformatf("beat%0d_addr", k), mem_address, {addr[31:2], 2'(k)});
        if (we) check($sformatf("beat%0d_wbyte", k), mem_data_in, wdata[8*k +: 8]);
        check($sformatf("beat%0d_acks", k), {r0_ack, r1_ack}, 0);
        if (drop && k == 1) drive(id, 1'b0, !we, $urandom, $urandom);
      end
    end
    @(negedge clk);
    check("ack_own", id ? r1_ack : r0_ack, 1);
    check("ack_other", id ? r0_ack : r1_ack, 0);
    check("ack_rdata", id ? r1_rdata : r0_rdata, exp);
    check("ack_err", err, mis);
    check("ack_mem_idle", {mem_read, mem_write}, 0);
    if (we && !mis)
      for (int k = 0; k < 4; k++) ref_mem[a + 8'(k)] = wdata[8*k +: 8];
    drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int ack_cyc [$];
    bit ack_id  [$];
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end

    // Store then load of the same word by different requesters.
    apply_reset();
    txn(0, 1, 32'h0, 32'hDEADBEEF, 0, 0);
    txn(1, 0, 32'h0, 32'h0, 0, 0);
    check("load_back_const", r1_rdata, 32'hDEADBEEF);

    // Misaligned load: error ack one cycle after grant, no memory traffic.
    txn(1, 0, 32'h6, 32'h0, 0, 0);

    // Continuous contention from reset: alternating grants, acks 6 cycles apart.
    apply_reset();
    @(negedge clk);
    drive(0, 1, 0, 32'h10, 0);
    drive(1, 1, 0, 32'h20, 0);
    for (int t = 0; t < 40 && ack_id.size() < 4; t++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        ack_id.push_back(r1_ack);
        ack_cyc.push_back(cyc);
        check("cont_rdata", r1_ack ? r1_rdata : r0_rdata,
              ref_word(r1_ack ? 32'h20 : 32'h10));
      end
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("cont_ack_count", ack_id.size(), 4);
    for (int i = 0; i < ack_id.size(); i++) begin
      check($sformatf("cont_order%0d", i), ack_id[i], i % 2);
      if (i > 0) check($sformatf("cont_spacing%0d", i), ack_cyc[i] - ack_cyc[i-1], 6);
    end
    repeat (2) @(negedge clk);

    // Reset during beat 2 of a store aborts it; the next tie goes to requester 0.
    model_last = 1'b1;
    @(negedge clk);
    drive(0, 1, 1, 32'h40, 32'h11223344);
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("abort_in_beat2", mem_address, 32'h42);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) ref_mem[8'h40 + 8'(k)] = 8'h44 - 8'(k * 8'h11);
    @(negedge clk);
    check("abort_mem_write", mem_write, 0);
    check("abort_busy", busy, 0);
    check("abort_r0_ack", r0_ack, 0);
    @(negedge clk);
    check("abort_r0_ack2", r0_ack, 0);
    reset = 1'b1;
    model_last = 1'b1;
    txn(0, 0, 32'h40, 32'h0, 0, 1);

    // Requester drops req in beat 1 of a load; the latched load still completes.
    txn(0, 0, 32'h0, 32'h0, 1, 0);

    // Randomized traffic against the byte-array model.
    for (int n = 0; n < 24; n++) begin
      bit          id, we, tie, drop;
      logic [31:0] addr;
      id   = 1'($urandom);
      we   = 1'($urandom);
      addr = {24'h0, 6'($urandom_range(0, 60)), 2'b00};
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      tie  = 1'($urandom) && (id != model_last);
      drop = 1'($urandom);
      txn(id, we, addr, $urandom, drop, tie);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
